// File: rtl/UART_pkg.sv
// UART_pkg: shared UART defaults, including the TX arbiter's requester count and burst limit.
package UART_pkg;
    localparam int ARB_N_REQ     = 4;
    localparam int ARB_MAX_BURST = 8;
endpackage

// File: rtl/fsm_pkg.sv
// fsm_pkg: state enums for the UART transmitter and its write-port arbiter.
package fsm_pkg;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_fsm_e;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DRAIN, ARB_CFG} arbiter_fsm_e;
endpackage

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: one-hot pick of the first valid bit at or after rr_ptr, wrapping around.
module rr_priority_encoder #(
    parameter int N_REQ = 4
) (
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    input  logic [N_REQ-1:0]         valid,
    output logic [N_REQ-1:0]         grant,
    output logic                     any_valid
);
    logic [N_REQ-1:0] rot_valid;
    logic [N_REQ-1:0] pick;
    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_valid = N_REQ'({valid, valid} >> rr_ptr);
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot_valid[i]) pick = N_REQ'(1) << i;
        grant = N_REQ'(({pick, pick} << rr_ptr) >> N_REQ);
    end
    assign any_valid = |valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the UART TX FIFO write port among byte requesters,
// with master config requests issued only once the FIFO is drained and the transmitter idle.
module uart_tx_arbiter
    import UART_pkg::*;
    import fsm_pkg::*;
#(
    parameter int N_REQ     = ARB_N_REQ,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ*8-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_fifo_write_o,
    input  logic                 tx_fifo_full_i,
    input  logic                 tx_fifo_empty_i,
    input  logic                 tx_idle_i,
    input  logic                 cfg_req_i,
    output logic                 cfg_req_mst_o,
    input  logic                 req_done_i,
    output logic                 cfg_ack_o
);
    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arbiter_fsm_e     state, state_nxt;
    logic [N_REQ-1:0] grant, enc_grant;
    logic             enc_any;
    logic [PW-1:0]    rr_ptr, gidx, enc_idx;
    logic [BW-1:0]    burst_cnt;
    logic             cfg_ack;
    logic             g_valid, g_last, accept, burst_end, start;
    logic [7:0]       g_data;

    rr_priority_encoder #(.N_REQ(N_REQ)) u_enc (
        .rr_ptr    (rr_ptr),
        .valid     (req_valid_i),
        .grant     (enc_grant),
        .any_valid (enc_any)
    );

    // Grant is one-hot or zero, so an AND-OR mux yields zero data when nobody is granted.
    always_comb begin
        enc_idx = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (enc_grant[i]) enc_idx = PW'(i);
            if (grant[i]) begin
                g_valid = req_valid_i[i];
                g_last  = req_last_i[i];
                g_data  = req_data_i[i*8 +: 8];
            end
        end
    end

    assign start           = (state == ARB_IDLE) && !cfg_req_i && enc_any;
    assign accept          = (state == ARB_GRANT) && g_valid && !tx_fifo_full_i;
    assign burst_end       = accept && (g_last || burst_cnt == BW'(MAX_BURST - 1));
    assign req_ready_o     = (state == ARB_GRANT && !tx_fifo_full_i) ? grant : '0;
    assign grant_o         = grant;
    assign tx_data_o       = g_data;
    assign tx_fifo_write_o = accept;
    assign cfg_req_mst_o   = state == ARB_CFG;
    assign cfg_ack_o       = cfg_ack;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  state_nxt = cfg_req_i ? ARB_DRAIN : enc_any ? ARB_GRANT : ARB_IDLE;
            ARB_GRANT: state_nxt = burst_end ? ARB_IDLE : ARB_GRANT;
            ARB_DRAIN: state_nxt = (tx_fifo_empty_i && tx_idle_i) ? ARB_CFG : ARB_DRAIN;
            ARB_CFG:   state_nxt = req_done_i ? ARB_IDLE : ARB_CFG;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            gidx      <= '0;
            burst_cnt <= '0;
            grant     <= '0;
            cfg_ack   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_ack <= (state == ARB_CFG) && req_done_i;
            if (start) begin
                grant     <= enc_grant;
                gidx      <= enc_idx;
                burst_cnt <= '0;
            end
            if (accept) burst_cnt <= burst_cnt + 1'b1;
            if (burst_end) begin
                grant  <= '0;
                rr_ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule
